// File: rtl/apb_master_decoder.sv
// Single-outstanding APB master: host valid/ready command in, APB SETUP/ACCESS out,
// with the 8-entry one-hot register decode folded into the SETUP capture.
module apb_master_decoder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] pwdata,
  output logic [7:0] select_reg,
  input  logic       pready,
  input  logic       psvlerr
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic       write;
    logic [7:0] wdata;
    logic [7:0] sel;
  } req_t;

  state_e        state_q;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q;
  logic          cmd_ready_q, psel_q, penable_q, rsp_valid_q, rsp_err_q;
  logic          done;

  // Out-of-range addresses decode to no select; the register block flags them.
  always_comb begin
    req_d       = '0;
    req_d.write = cmd_write;
    req_d.wdata = cmd_wdata;
    if (cmd_addr[7:3] == 5'd0) req_d.sel[cmd_addr[2:0]] = 1'b1;
  end

  assign done = (state_q == ACCESS) &&
                (pready || psvlerr || (cnt_q == CW'(TIMEOUT - 1)));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q     <= SETUP;
            req_q       <= req_d;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            // Timeout (neither handshake) reports as an error too.
            rsp_err_q   <= psvlerr | ~pready;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = req_q.write;
  assign pwdata     = req_q.wdata;
  assign select_reg = req_q.sel;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_apb_master_decoder.sv
// Bench for apb_master_decoder: slave model with several personalities, a cycle-indexed
// expected-output timeline built per accepted command, directed cases and a random stream.
module tb_apb_master_decoder;
  localparam int TO = 4;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [7:0] pwdata, select_reg;
  logic       pready, psvlerr;

  apb_master_decoder #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .select_reg(select_reg), .pready(pready), .psvlerr(psvlerr)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Expected outputs per cycle: {cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pwdata, select_reg}
  typedef struct packed {
    logic rdy, rv, re, ps, pe, pw;
    logic [7:0] wd, sel;
  } out_t;

  function automatic out_t idle_row();
    out_t r;
    r     = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  out_t exp_tab [int];
  int   cyc = 0, busy_until = 0, acc_cnt = 0, acc_cyc = 0, force_mode = 0;
  int   act_mode = 0, act_lat = 1;
  logic act_ef = 1'b0, act_bf = 1'b0;
  int   m_mode, m_len;
  logic m_err;
  logic [7:0] m_sel;
  out_t m_row;

  // Reference model: one accepted command lays out SETUP, L ACCESS cycles, then a response cycle.
  always @(posedge pclk) begin
    if (!preset && cmd_valid && cyc >= busy_until) begin
      m_mode  = (force_mode >= 0) ? force_mode : int'($urandom_range(0, 2));
      act_lat = int'($urandom_range(1, TO + 2));
      act_ef  = 1'($urandom_range(0, 1));
      act_bf  = 1'($urandom_range(0, 1));
      m_sel   = (cmd_addr[7:3] == 5'd0) ? (8'h01 << cmd_addr[2:0]) : 8'h00;
      case (m_mode)
        0:       begin m_len = 1;  m_err = (m_sel == 8'h00); end
        1:       begin m_len = TO; m_err = 1'b1; end
        default: begin
          if (act_lat > TO) begin m_len = TO; m_err = 1'b1; end
          else begin m_len = act_lat; m_err = act_ef; end
        end
      endcase
      act_mode = m_mode;
      m_row = '0;
      m_row.ps = 1'b1; m_row.pw = cmd_write; m_row.wd = cmd_wdata; m_row.sel = m_sel;
      exp_tab[cyc + 1] = m_row;
      m_row.pe = 1'b1;
      for (int k = 1; k <= m_len; k++) exp_tab[cyc + 1 + k] = m_row;
      m_row = idle_row();
      m_row.rv = 1'b1; m_row.re = m_err;
      exp_tab[cyc + 2 + m_len] = m_row;
      busy_until = cyc + 2 + m_len;
      acc_cyc    = cyc;
      acc_cnt++;
    end
    cyc++;
  end

  // Slave: mode 0 = register block, 1 = silent stub, 2 = random latency/error with idle noise.
  logic       r_rdy = 1'b0, r_err = 1'b1, nz_rdy = 1'b0, nz_err = 1'b0, hit;
  int         acc_n = 0;
  logic [7:0] regs [8] = '{default: 8'h00};

  always @(posedge pclk) begin
    r_rdy  <= (select_reg != 8'h00);
    r_err  <= (select_reg == 8'h00);
    nz_rdy <= 1'($urandom_range(0, 1));
    nz_err <= 1'($urandom_range(0, 1));
    acc_n  <= (psel && penable) ? acc_n + 1 : 0;
    if (act_mode == 0 && psel && penable && pready && !psvlerr && pwrite)
      for (int i = 0; i < 8; i++) if (select_reg[i]) regs[i] <= pwdata;
  end

  assign hit = psel && penable && (acc_n == act_lat - 1);

  always_comb begin
    pready  = 1'b0;
    psvlerr = 1'b0;
    case (act_mode)
      0: begin pready = r_rdy; psvlerr = r_err; end
      1: ;
      default: begin
        if (psel && penable) begin
          pready  = hit && (!act_ef || act_bf);
          psvlerr = hit && act_ef;
        end else begin
          pready  = nz_rdy;
          psvlerr = nz_err;
        end
      end
    endcase
  end

  out_t got_o, exp_o;
  always @(negedge pclk) begin
    got_o = {cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pwdata, select_reg};
    exp_o = exp_tab.exists(cyc) ? exp_tab[cyc] : idle_row();
    chk($sformatf("outputs@cyc%0d", cyc), 32'(got_o), 32'(exp_o));
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= busy_until && n < 64) begin @(negedge pclk); n++; end
    if (cyc <= busy_until) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: still busy at cyc %0d, required idle by %0d", cyc, busy_until);
    end
  endtask

  int         n, k, prev, bad_rdy, rsp_hi, diff;
  int         rsp_q [$];
  logic [7:0] sel_q [$];
  logic [7:0] b2b_addr [3] = '{8'h00, 8'h07, 8'h05};
  logic [7:0] pre_regs [8];

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    repeat (2) @(negedge pclk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_outputs", 32'({psel, penable, pwrite, rsp_valid, rsp_err, pwdata, select_reg}), 32'(0));
    preset = 1'b0;

    // Write 0x03 <- 0xA5 through the register block
    force_mode = 0;
    wait_idle(); send(1'b1, 8'h03, 8'hA5);
    chk("wr03_setup", 32'({psel, penable, pwrite, pwdata, select_reg}), 32'({3'b101, 8'hA5, 8'h08}));
    @(negedge pclk); chk("wr03_access_penable", 32'(penable), 32'(1));
    @(negedge pclk); chk("wr03_rsp", 32'({rsp_valid, rsp_err}), 32'(2'b10));
    chk("wr03_latency", 32'(cyc - acc_cyc), 32'(3));
    chk("wr03_reg3", 32'(regs[3]), 32'(8'hA5));

    // Out-of-range write
    wait_idle(); send(1'b1, 8'h20, 8'h3C);
    chk("oor_setup_sel", 32'(select_reg), 32'(0));
    @(negedge pclk); chk("oor_access", 32'({penable, select_reg, psvlerr}), 32'({1'b1, 8'h00, 1'b1}));
    @(negedge pclk); chk("oor_rsp", 32'({rsp_valid, rsp_err}), 32'(2'b11));

    // Timeout against a silent slave
    force_mode = 1;
    wait_idle(); send(1'b1, 8'h02, 8'h77);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (penable) n++; else break;
    end
    chk("to_access_len", 32'(n), 32'(TO));
    chk("to_rsp", 32'({rsp_valid, rsp_err, psel}), 32'(3'b110));

    // Back-to-back with cmd_valid held high
    force_mode = 0;
    wait_idle();
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = b2b_addr[0]; cmd_wdata = 8'h11;
    k = 0; prev = acc_cnt; bad_rdy = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge pclk);
      if (acc_cnt != prev) begin
        prev = acc_cnt; k++;
        if (k < 3) begin cmd_addr = b2b_addr[k]; cmd_wdata = 8'h11 + 8'(k); end
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) rsp_q.push_back(cyc);
      if (psel && !penable) sel_q.push_back(select_reg);
      if (cmd_ready === psel) bad_rdy++;
    end
    chk("b2b_rsp_count", 32'(rsp_q.size()), 32'(3));
    chk("b2b_gap1", 32'(rsp_q[1] - rsp_q[0]), 32'(3));
    chk("b2b_gap2", 32'(rsp_q[2] - rsp_q[1]), 32'(3));
    chk("b2b_sel_seq", 32'({sel_q[0], sel_q[1], sel_q[2]}), 32'(24'h018020));
    chk("b2b_ready_vs_busy", 32'(bad_rdy), 32'(0));

    // Reset in the middle of ACCESS
    force_mode = 1;
    wait_idle(); send(1'b1, 8'h04, 8'h99);
    @(negedge pclk); chk("mid_in_access", 32'(penable), 32'(1));
    #2 preset = 1'b1;
    exp_tab.delete(); busy_until = 0;
    #1 chk("mid_rst_outputs",
           32'({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, pwdata, select_reg}),
           32'({1'b1, 21'h0}));
    @(negedge pclk); @(negedge pclk); preset = 1'b0;
    rsp_hi = 0;
    repeat (6) begin @(negedge pclk); if (rsp_valid) rsp_hi++; end
    chk("mid_no_rsp", 32'(rsp_hi), 32'(0));
    force_mode = 0;
    wait_idle(); send(1'b1, 8'h01, 8'h5E);
    chk("post_rst_sel", 32'(select_reg), 32'(8'h02));
    @(negedge pclk); @(negedge pclk);
    chk("post_rst_rsp", 32'({rsp_valid, rsp_err}), 32'(2'b10));

    // Read 0x06 leaves the register block untouched
    wait_idle();
    pre_regs = regs;
    send(1'b0, 8'h06, 8'h5A);
    chk("rd06_setup", 32'({psel, pwrite, select_reg}), 32'({1'b1, 1'b0, 8'h40}));
    @(negedge pclk); @(negedge pclk);
    chk("rd06_rsp", 32'({rsp_valid, rsp_err}), 32'(2'b10));
    diff = 0;
    for (int i = 0; i < 8; i++) if (regs[i] !== pre_regs[i]) diff++;
    chk("rd06_regs_unchanged", 32'(diff), 32'(0));

    // Random command stream across all slave personalities
    force_mode = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      cmd_wdata = 8'($urandom);
    end
    @(negedge pclk); cmd_valid = 1'b0;
    repeat (20) @(negedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
